// File: rtl/shots_pkg.sv
// shots_pkg: shared types and constants for the shot engine.
//   shot_t            - one shot slot: active flag, owner, top-left position
//   SHOT_RGB_PLAYER   - colour of a player shot
//   SHOT_RGB_ENEMY    - colour of an enemy shot
//   COLOR_TRANSPARENT - colour driven when no shot covers the pixel
package shots_pkg;

    typedef struct packed {
        logic        active;
        logic        ownerPlayer;
        logic [10:0] x;
        logic [10:0] y;
    } shot_t;

    localparam logic [7:0] SHOT_RGB_PLAYER   = 8'hFC;
    localparam logic [7:0] SHOT_RGB_ENEMY    = 8'hE0;
    localparam logic [7:0] COLOR_TRANSPARENT = 8'h00;

endpackage

// File: rtl/shot_arbiter.sv
// shot_arbiter: latches shoot requests and picks one source per cycle.
// The player (index ENEMY_COUNT) has fixed priority; enemies are served
// round-robin starting at the pointer, which moves past each enemy winner.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   flush           - level start: clears pending and pointer, blocks grant
//   slot_free       - at least one shot slot is free this cycle
//   enemy_request   - per-enemy request
//   player_request  - player request
//   grant           - combinational one-hot grant (player is the MSB)
//   grant_src       - index of the granted source
//   grant_valid     - a grant is issued this cycle
module shot_arbiter #(
    parameter int unsigned ENEMY_COUNT = 8,
    localparam int unsigned SRC_W = $clog2(ENEMY_COUNT + 1),
    localparam int unsigned PTR_W = (ENEMY_COUNT > 1) ? $clog2(ENEMY_COUNT) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   slot_free,
    input  logic [ENEMY_COUNT-1:0] enemy_request,
    input  logic                   player_request,
    output logic [ENEMY_COUNT:0]   grant,
    output logic [SRC_W-1:0]       grant_src,
    output logic                   grant_valid
);

    logic [ENEMY_COUNT:0]   pending_q, pending_d;
    logic [ENEMY_COUNT-1:0] enemy_pending;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       idx, win;
    logic                   found;

    assign enemy_pending = pending_q[ENEMY_COUNT-1:0];

    always_comb begin
        grant       = '0;
        grant_src   = '0;
        grant_valid = 1'b0;
        ptr_d       = ptr_q;
        idx         = '0;
        win         = '0;
        found       = 1'b0;
        // First pending enemy at or after the pointer, wrapping around.
        for (int unsigned k = 0; k < ENEMY_COUNT; k++) begin
            idx = PTR_W'((32'(ptr_q) + k) % ENEMY_COUNT);
            if (!found && enemy_pending[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (slot_free && !flush) begin
            if (pending_q[ENEMY_COUNT]) begin
                grant[ENEMY_COUNT] = 1'b1;
                grant_src          = SRC_W'(ENEMY_COUNT);
                grant_valid        = 1'b1;
            end else if (found) begin
                grant       = (ENEMY_COUNT + 1)'(1) << win;
                grant_src   = SRC_W'(win);
                grant_valid = 1'b1;
                ptr_d       = PTR_W'((32'(win) + 1) % ENEMY_COUNT);
            end
        end
        if (flush) begin
            pending_d = '0;
            ptr_d     = '0;
        end else begin
            pending_d = (pending_q & ~grant) | {player_request, enemy_request};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            ptr_q     <= '0;
        end else begin
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
        end
    end

endmodule

// File: rtl/shots_manager.sv
// shots_manager: projectile engine. Allocates granted shoot requests to a
// pool of shot slots, moves shots each frame, retires them on exit or hit,
// and renders them for the VGA mux and collision logic.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   startOfFrame          - one-cycle pulse per frame, moves all shots
//   startOfLevel          - one-cycle pulse, flushes slots and requests
//   enemyShootRequest     - per-enemy shoot request
//   playerShootRequest    - player shoot request
//   bikersX, bikersY      - biker top-left positions (index N is the player)
//   shotHit               - per-slot collision, retires the slot
//   pixelX, pixelY        - current VGA pixel
//   shootGrant            - one-hot pulse when a source's shot is spawned
//   shotDrawingVector     - per-slot "pixel inside this shot"
//   shotOwnerPlayer       - per-slot "holds an active player shot"
//   shotDrawingRequest    - any slot drawing
//   RGBshot               - colour of the lowest drawing slot
module shots_manager
    import shots_pkg::*;
#(
    parameter int ENEMY_BIKERS_COUNT = 8,
    parameter int SHOT_SLOTS         = 8,
    parameter int SHOT_SPEED         = 4,
    parameter int SHOT_W             = 4,
    parameter int SHOT_H             = 8,
    parameter int BIKER_W            = 32,
    parameter int BIKER_H            = 32,
    parameter int SCREEN_H           = 480
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 startOfFrame,
    input  logic                                 startOfLevel,
    input  logic [ENEMY_BIKERS_COUNT-1:0]        enemyShootRequest,
    input  logic                                 playerShootRequest,
    input  logic [ENEMY_BIKERS_COUNT:0][10:0]    bikersX,
    input  logic [ENEMY_BIKERS_COUNT:0][10:0]    bikersY,
    input  logic [SHOT_SLOTS-1:0]                shotHit,
    input  logic [10:0]                          pixelX,
    input  logic [10:0]                          pixelY,
    output logic [ENEMY_BIKERS_COUNT:0]          shootGrant,
    output logic [SHOT_SLOTS-1:0]                shotDrawingVector,
    output logic [SHOT_SLOTS-1:0]                shotOwnerPlayer,
    output logic                                 shotDrawingRequest,
    output logic [7:0]                           RGBshot
);

    localparam int SRC_W  = $clog2(ENEMY_BIKERS_COUNT + 1);
    localparam int SLOT_W = (SHOT_SLOTS > 1) ? $clog2(SHOT_SLOTS) : 1;
    localparam logic [10:0] SPAWN_X_OFS = 11'(BIKER_W / 2 - SHOT_W / 2);
    localparam logic [10:0] SPEED       = 11'(SHOT_SPEED);
    localparam logic [10:0] SHOT_H_11   = 11'(SHOT_H);
    localparam logic [10:0] BIKER_H_11  = 11'(BIKER_H);
    localparam logic [10:0] SCREEN_H_11 = 11'(SCREEN_H);

    shot_t slots_q [SHOT_SLOTS];
    shot_t slots_d [SHOT_SLOTS];
    shot_t spawn;

    logic [SHOT_SLOTS-1:0]         free_mask;
    logic [SLOT_W-1:0]             alloc_idx;
    logic [ENEMY_BIKERS_COUNT:0]   grant;
    logic [SRC_W-1:0]              grant_src;
    logic                          grant_valid;
    logic [10:0]                   moved_y;
    logic [SHOT_SLOTS-1:0]         draw_d, owner_d;
    logic [7:0]                    rgb_d;
    logic                          drawn;
    logic [11:0]                   px, py, sx, sy;

    // Free mask comes from registered state only; a slot freed this cycle is
    // allocatable on the next one.
    always_comb begin
        alloc_idx = '0;
        for (int s = 0; s < SHOT_SLOTS; s++) begin
            free_mask[s] = ~slots_q[s].active;
        end
        for (int s = SHOT_SLOTS - 1; s >= 0; s--) begin
            if (free_mask[s]) alloc_idx = SLOT_W'(s);
        end
    end

    shot_arbiter #(
        .ENEMY_COUNT (ENEMY_BIKERS_COUNT)
    ) u_arbiter (
        .clk            (clk),
        .reset          (reset),
        .flush          (startOfLevel),
        .slot_free      (|free_mask),
        .enemy_request  (enemyShootRequest),
        .player_request (playerShootRequest),
        .grant          (grant),
        .grant_src      (grant_src),
        .grant_valid    (grant_valid)
    );

    // Spawn shot from the granted biker's current position.
    always_comb begin
        spawn             = '0;
        spawn.active      = 1'b1;
        spawn.ownerPlayer = (grant_src == SRC_W'(ENEMY_BIKERS_COUNT));
        spawn.x           = bikersX[grant_src] + SPAWN_X_OFS;
        if (spawn.ownerPlayer) begin
            spawn.y = (bikersY[grant_src] >= SHOT_H_11) ? bikersY[grant_src] - SHOT_H_11 : '0;
        end else begin
            spawn.y = bikersY[grant_src] + BIKER_H_11;
        end
    end

    // Slot update: hit beats move; the freshly spawned slot is not moved.
    always_comb begin
        moved_y = '0;
        for (int s = 0; s < SHOT_SLOTS; s++) begin
            slots_d[s] = slots_q[s];
            if (slots_q[s].active) begin
                if (shotHit[s]) begin
                    slots_d[s].active = 1'b0;
                end else if (startOfFrame) begin
                    if (slots_q[s].ownerPlayer) begin
                        if (slots_q[s].y < SPEED) slots_d[s].active = 1'b0;
                        else                      slots_d[s].y = slots_q[s].y - SPEED;
                    end else begin
                        moved_y = slots_q[s].y + SPEED;
                        if (moved_y >= SCREEN_H_11) slots_d[s].active = 1'b0;
                        else                        slots_d[s].y = moved_y;
                    end
                end
            end
            if (grant_valid && alloc_idx == SLOT_W'(s)) slots_d[s] = spawn;
            if (startOfLevel) slots_d[s].active = 1'b0;
            owner_d[s] = slots_d[s].active & slots_d[s].ownerPlayer;
        end
    end

    // Render comparators, widened to 12 bits so x+SHOT_W cannot wrap.
    always_comb begin
        rgb_d = COLOR_TRANSPARENT;
        drawn = 1'b0;
        px    = {1'b0, pixelX};
        py    = {1'b0, pixelY};
        sx    = '0;
        sy    = '0;
        for (int s = 0; s < SHOT_SLOTS; s++) begin
            sx        = {1'b0, slots_q[s].x};
            sy        = {1'b0, slots_q[s].y};
            draw_d[s] = slots_q[s].active
                        && px >= sx && px < sx + 12'(SHOT_W)
                        && py >= sy && py < sy + 12'(SHOT_H);
            if (draw_d[s] && !drawn) begin
                drawn = 1'b1;
                rgb_d = slots_q[s].ownerPlayer ? SHOT_RGB_PLAYER : SHOT_RGB_ENEMY;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SHOT_SLOTS; s++) slots_q[s] <= '0;
            shootGrant         <= '0;
            shotDrawingVector  <= '0;
            shotOwnerPlayer    <= '0;
            shotDrawingRequest <= 1'b0;
            RGBshot            <= COLOR_TRANSPARENT;
        end else begin
            for (int s = 0; s < SHOT_SLOTS; s++) slots_q[s] <= slots_d[s];
            shootGrant         <= grant;
            shotDrawingVector  <= draw_d;
            shotOwnerPlayer    <= owner_d;
            shotDrawingRequest <= |draw_d;
            RGBshot            <= rgb_d;
        end
    end

endmodule
